// File: rtl/obs_mul_seq_if.sv
// Handshake and operand/result bus for obs_mul_seq.
//   in_valid/in_ready : operand handshake (a, b, sq)
//   out_valid/out_ready: result handshake (y, 2N-1 bits)
// master drives operands and out_ready; slave is the multiplier.
interface obs_mul_seq_if #(
  parameter int unsigned N = 97
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           sq;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-2:0] y;

  modport master (
    output in_valid, a, b, sq, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, sq, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/obs_mul_seq.sv
// Multi-cycle GF(2) polynomial multiplier with one odd-even split.
// The three half-width sub-products (even, odd, cross) share one
// digit-serial datapath consuming D bits of the q half per cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : obs_mul_seq_if slave (in_valid/in_ready, a, b, sq,
//           out_valid/out_ready, y)
module obs_mul_seq #(
  parameter int unsigned N = 97,
  parameter int unsigned D = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  obs_mul_seq_if.slave  bus
);

  localparam int unsigned H  = (N + 1) / 2;
  localparam int unsigned C  = (H + D - 1) / D;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned AW = 2 * H - 1;      // sub-product width
  localparam int unsigned QW = C * D;          // q half padded to whole digits
  localparam int unsigned PW = H + QW - 1;     // widest shifted partial product
  localparam int unsigned YW = 2 * AW + 2;     // recombined width before trim
  localparam int unsigned OW = 2 * N - 1;

  typedef enum logic [2:0] {
    IDLE, MUL_EE, MUL_OO, MUL_XX, COMBINE, SQ, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, b_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   acc_q, pe_q, po_q, px_q;
  logic            in_ready_q, out_valid_q;
  logic [OW-1:0]   y_q;

  logic            accept_c;
  logic            last_c;
  logic [2*H-1:0]  a_pad, b_pad;
  logic [H-1:0]    ae, ao, be, bo;
  logic [H-1:0]    p_c, q_c;
  logic [QW-1:0]   q_pad;
  logic [D-1:0]    digit_c;
  logic [PW-1:0]   contrib_c;
  logic [AW-1:0]   acc_next_c;
  logic [YW-1:0]   y_full_c;
  logic [OW-1:0]   y_mul_c, y_sq_c;

  function automatic logic [2*AW-1:0] spread_sub(input logic [AW-1:0] v);
    spread_sub = '0;
    for (int i = 0; i < int'(AW); i++) spread_sub[2*i] = v[i];
  endfunction

  assign accept_c = (state_q == IDLE) && bus.in_valid;
  assign last_c   = (cnt_q == CW'(C - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = bus.sq ? SQ : MUL_EE;
      MUL_EE:  if (last_c) state_d = MUL_OO;
      MUL_OO:  if (last_c) state_d = MUL_XX;
      MUL_XX:  if (last_c) state_d = COMBINE;
      COMBINE: state_d = DONE;
      SQ:      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Odd/even split of latched operands; odd N leaves the top odd bit zero
  always_comb begin
    a_pad = (2*H)'(a_q);
    b_pad = (2*H)'(b_q);
    ae = '0; ao = '0; be = '0; bo = '0;
    for (int i = 0; i < int'(H); i++) begin
      ae[i] = a_pad[2*i];
      ao[i] = a_pad[2*i+1];
      be[i] = b_pad[2*i];
      bo[i] = b_pad[2*i+1];
    end
  end

  // Operand select for the shared digit-serial datapath
  always_comb begin
    p_c = ae ^ ao;
    q_c = be ^ bo;
    case (state_q)
      MUL_EE:  begin p_c = ae; q_c = be; end
      MUL_OO:  begin p_c = ao; q_c = bo; end
      default: ;
    endcase
  end

  // One digit step: acc ^= (p * q_digit) << (cnt*D); padding masks the last digit
  always_comb begin
    q_pad     = QW'(q_c);
    digit_c   = q_pad[int'(cnt_q) * int'(D) +: D];
    contrib_c = '0;
    for (int j = 0; j < int'(D); j++) begin
      if (digit_c[j]) contrib_c = contrib_c ^ (PW'(p_c) << (int'(cnt_q) * int'(D) + j));
    end
    acc_next_c = acc_q ^ AW'(contrib_c);
  end

  // Recombination and squaring
  always_comb begin
    y_full_c = YW'(spread_sub(pe_q))
             ^ (YW'(spread_sub(po_q)) << 2)
             ^ (YW'(spread_sub(pe_q ^ po_q ^ px_q)) << 1);
    y_mul_c  = OW'(y_full_c);
    y_sq_c   = '0;
    for (int i = 0; i < int'(N); i++) y_sq_c[2*i] = a_q[i];
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      pe_q        <= '0;
      po_q        <= '0;
      px_q        <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          acc_q <= '0;
          if (accept_c) begin
            a_q <= bus.a;
            b_q <= bus.b;
          end
        end
        MUL_EE, MUL_OO, MUL_XX: begin
          if (last_c) begin
            cnt_q <= '0;
            acc_q <= '0;
            if (state_q == MUL_EE)      pe_q <= acc_next_c;
            else if (state_q == MUL_OO) po_q <= acc_next_c;
            else                        px_q <= acc_next_c;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= acc_next_c;
          end
        end
        COMBINE: y_q <= y_mul_c;
        SQ:      y_q <= y_sq_c;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

endmodule

// File: tb/tb_obs_mul_seq.sv
// Directed and random checks of obs_mul_seq: N=97/D=7 main instance plus
// three N=8 instances (D=3, 4, 1) that must agree on the same product.
module tb_obs_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obs_mul_seq_if #(.N(97)) m ();
  obs_mul_seq_if #(.N(8))  i3 ();
  obs_mul_seq_if #(.N(8))  i4 ();
  obs_mul_seq_if #(.N(8))  i1 ();

  obs_mul_seq #(.N(97), .D(7)) u_dut97 (.clk(clk), .rst_n(rst_n), .bus(m));
  obs_mul_seq #(.N(8),  .D(3)) u_dut8d3 (.clk(clk), .rst_n(rst_n), .bus(i3));
  obs_mul_seq #(.N(8),  .D(4)) u_dut8d4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  obs_mul_seq #(.N(8),  .D(1)) u_dut8d1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Plain shift-and-xor carry-less reference
  function automatic logic [192:0] clmul97(input logic [96:0] x, input logic [96:0] z);
    logic [192:0] r;
    r = '0;
    for (int i = 0; i < 97; i++) if (z[i]) r = r ^ (193'(x) << i);
    return r;
  endfunction

  function automatic logic [96:0] rnd97();
    return 97'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Present operands for one edge, then scramble them to test latching
  task automatic do_accept(input logic [96:0] a, input logic [96:0] b, input logic sq);
    m.in_valid = 1'b1; m.a = a; m.b = b; m.sq = sq;
    @(posedge clk); #1;
    m.in_valid = 1'b0; m.a = ~a; m.b = rnd97(); m.sq = ~sq;
  endtask

  // Edges after the accept edge until out_valid is seen; flags in_ready high meanwhile
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!m.out_valid && lat < 200) begin
      if (m.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (m.in_ready) busy_ok = 1'b0;
  endtask

  task automatic handshake(input int stall);
    repeat (stall) begin @(posedge clk); #1; end
    m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic busy_ok;
    logic [96:0] ra, rb;
    logic [192:0] y0;
    int lat3, lat4, lat1, bad_rand;

    m.in_valid = 1'b0; m.a = '0; m.b = '0; m.sq = 1'b0; m.out_ready = 1'b0;
    i3.in_valid = 1'b0; i3.a = '0; i3.b = '0; i3.sq = 1'b0; i3.out_ready = 1'b0;
    i4.in_valid = 1'b0; i4.a = '0; i4.b = '0; i4.sq = 1'b0; i4.out_ready = 1'b0;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.sq = 1'b0; i1.out_ready = 1'b0;

    #12;
    check("rst_in_ready", 256'(m.in_ready), 256'(1));
    check("rst_out_valid", 256'(m.out_valid), 256'(0));
    check("rst_y", 256'(m.y), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 256'(m.in_ready), 256'(1));

    // 1 * 1
    do_accept(97'd1, 97'd1, 1'b0);
    wait_done(lat, busy_ok);
    check("one_y", 256'(m.y), 256'(1));
    check("one_latency", 256'(lat), 256'(22));
    check("one_busy", 256'(busy_ok), 256'(1));
    handshake(0);
    check("one_hs_in_ready", 256'(m.in_ready), 256'(1));
    check("one_hs_out_valid", 256'(m.out_valid), 256'(0));

    // x^96 * x^96
    ra = 97'd1 << 96;
    do_accept(ra, ra, 1'b0);
    wait_done(lat, busy_ok);
    check("top_y", 256'(m.y), 256'(193'd1 << 192));
    handshake(2);

    // all ones against the reference
    ra = '1;
    do_accept(ra, ra, 1'b0);
    wait_done(lat, busy_ok);
    check("ones_y", 256'(m.y), 256'(clmul97(ra, ra)));
    handshake(0);

    // square then back-to-back multiply at the earliest edge
    do_accept(97'b1011, rnd97(), 1'b1);
    wait_done(lat, busy_ok);
    check("sq_y", 256'(m.y), 256'(193'h45));
    check("sq_latency", 256'(lat), 256'(1));
    handshake(0);
    ra = rnd97(); rb = rnd97();
    do_accept(ra, rb, 1'b0);
    wait_done(lat, busy_ok);
    check("b2b_y", 256'(m.y), 256'(clmul97(ra, rb)));
    check("b2b_latency", 256'(lat), 256'(22));

    // backpressure: hold result while in_valid and operands toggle
    y0 = m.y;
    busy_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m.in_valid = 1'b1; m.a = rnd97(); m.b = rnd97(); m.sq = i[0];
      @(posedge clk); #1;
      if (m.y !== y0 || !m.out_valid || m.in_ready) busy_ok = 1'b0;
    end
    m.in_valid = 1'b0;
    check("bp_stable", 256'(busy_ok), 256'(1));
    check("bp_y", 256'(m.y), 256'(clmul97(ra, rb)));
    handshake(0);
    check("bp_no_accept_rdy", 256'(m.in_ready), 256'(1));
    repeat (3) begin @(posedge clk); #1; end
    check("bp_no_accept_valid", 256'(m.out_valid), 256'(0));
    check("bp_no_accept_rdy2", 256'(m.in_ready), 256'(1));

    // random pairs with random stalls
    bad_rand = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = rnd97(); rb = rnd97();
      do_accept(ra, rb, 1'b0);
      wait_done(lat, busy_ok);
      if (m.y !== clmul97(ra, rb) || lat != 22) bad_rand++;
      handshake(int'($urandom_range(0, 3)));
    end
    check("rand_mismatches", 256'(bad_rand), 256'(0));

    // reset in the middle of the odd sub-product
    do_accept(rnd97() | 97'd1, 97'd5, 1'b0);
    wait_done(lat, busy_ok);
    handshake(0);
    do_accept(rnd97(), rnd97(), 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 256'(m.out_valid), 256'(0));
    check("rst_mid_y", 256'(m.y), 256'(0));
    check("rst_mid_in_ready", 256'(m.in_ready), 256'(1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_accept(97'd3, 97'd3, 1'b0);
    wait_done(lat, busy_ok);
    check("rst_after_y", 256'(m.y), 256'(5));
    handshake(0);

    // N=8 across digit sizes
    i3.a = 8'hFF; i3.b = 8'hFF; i3.in_valid = 1'b1;
    i4.a = 8'hFF; i4.b = 8'hFF; i4.in_valid = 1'b1;
    i1.a = 8'hFF; i1.b = 8'hFF; i1.in_valid = 1'b1;
    @(posedge clk); #1;
    i3.in_valid = 1'b0; i4.in_valid = 1'b0; i1.in_valid = 1'b0;
    i3.a = 8'h00; i4.a = 8'h00; i1.a = 8'h00;
    lat3 = -1; lat4 = -1; lat1 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (i3.out_valid && lat3 < 0) lat3 = k;
      if (i4.out_valid && lat4 < 0) lat4 = k;
      if (i1.out_valid && lat1 < 0) lat1 = k;
    end
    check("n8_d3_y", 256'(i3.y), 256'(15'h5555));
    check("n8_d4_y", 256'(i4.y), 256'(15'h5555));
    check("n8_d1_y", 256'(i1.y), 256'(15'h5555));
    check("n8_d3_latency", 256'(lat3), 256'(7));
    check("n8_d4_latency", 256'(lat4), 256'(4));
    check("n8_d1_latency", 256'(lat1), 256'(13));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
